// File: rtl/apb_fifo_bridge_mc.sv
// apb_fifo_bridge_mc
//   APB3 slave that bridges the bus to a tagged async-FIFO pair.
//   - APB writes to channel i (paddr = BASE_ADDR+i) push {i, pwdata} into the write FIFO,
//     stalling with wait states while the write FIFO is full and erroring after WAIT_MAX cycles.
//   - Words drained from the read FIFO update per-channel shadow registers; APB reads
//     of a channel return its shadow value.
//   - STATUS (paddr = BASE_ADDR+NREG): bit0 write-full, bit1 read-empty (live),
//     bit2 sticky timeout, bit3 sticky bad-tag, bits[15:8] dropped-word count.
//     Bits 2 and 3 are write-1-to-clear; clearing bit 3 also clears the drop count.
//
// Ports:
//   pclk, preset_n           clock, asynchronous active-low reset
//   paddr/psel/penable/pwrite/pwdata   APB request
//   pready/prdata/pslverr    APB response (registered, pready is a one-cycle pulse)
//   fifo_read_empty/fifo_read_data/fifo_read_inc   read FIFO (first-word fall-through)
//   fifo_write_full/fifo_write_data/fifo_write_inc  write FIFO
module apb_fifo_bridge_mc #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int NREG      = 4,
  parameter int TAG_W     = 2,
  parameter int BASE_ADDR = 1,
  parameter int WAIT_MAX  = 16
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic [ADDR_W-1:0]       paddr,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_W-1:0]       pwdata,
  output logic                    pready,
  output logic [DATA_W-1:0]       prdata,
  output logic                    pslverr,
  input  logic                    fifo_read_empty,
  input  logic                    fifo_write_full,
  input  logic [TAG_W+DATA_W-1:0] fifo_read_data,
  output logic                    fifo_read_inc,
  output logic [TAG_W+DATA_W-1:0] fifo_write_data,
  output logic                    fifo_write_inc
);

  localparam int FIFO_W = TAG_W + DATA_W;
  localparam int CNT_W  = $clog2(WAIT_MAX + 1);
  localparam logic [ADDR_W-1:0] CHAN_LO     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] CHAN_N      = ADDR_W'(NREG);
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(BASE_ADDR + NREG);
  localparam logic [TAG_W:0]    NREG_T      = (TAG_W + 1)'(NREG);
  localparam logic [CNT_W-1:0]  WAIT_LAST   = CNT_W'(WAIT_MAX - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shadow [NREG];
  logic              timeout_flag, badtag_flag;
  logic [7:0]        drop_cnt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic [TAG_W-1:0]  cap_tag;
  logic [DATA_W-1:0] cap_data;
  logic              cap_load;

  logic              pready_nxt, pslverr_nxt, wr_inc_nxt;
  logic [DATA_W-1:0] prdata_nxt;
  logic [FIFO_W-1:0] wr_data_nxt;
  logic              timeout_set, clr_timeout, clr_badtag;

  logic              access, is_chan, is_status;
  logic [ADDR_W-1:0] rel_addr;
  logic [TAG_W-1:0]  chan_idx;
  logic              pop, rd_tag_ok, badtag_set;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] status_val;

  assign access    = psel & penable;
  assign rel_addr  = paddr - CHAN_LO;
  assign is_chan   = (paddr >= CHAN_LO) && (rel_addr < CHAN_N);
  assign is_status = (paddr == STATUS_ADDR);
  assign chan_idx  = rel_addr[TAG_W-1:0];

  // Drain side: the registered pop pulse blocks a second pop until the FIFO has
  // had a cycle to present its next head word.
  assign rd_tag     = fifo_read_data[FIFO_W-1:DATA_W];
  assign rd_data    = fifo_read_data[DATA_W-1:0];
  assign rd_tag_ok  = {1'b0, rd_tag} < NREG_T;
  assign pop        = !fifo_read_empty && !fifo_read_inc;
  assign badtag_set = pop && !rd_tag_ok;

  always_comb begin
    status_val       = '0;
    status_val[0]    = fifo_write_full;
    status_val[1]    = fifo_read_empty;
    status_val[2]    = timeout_flag;
    status_val[3]    = badtag_flag;
    status_val[15:8] = drop_cnt;
  end

  // State register.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic. Only a channel write that finds the FIFO full detours through WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (access) state_nxt = (is_chan && pwrite && fifo_write_full) ? WAIT : RESP;
      WAIT: if (!fifo_write_full || (wait_cnt == WAIT_LAST)) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/next-value logic. Everything here lands in registers, so pready appears
  // the cycle after the deciding access-phase cycle. In WAIT the push uses the
  // address/data captured on entry, not whatever is on the bus now.
  always_comb begin
    pready_nxt   = 1'b0;
    pslverr_nxt  = 1'b0;
    wr_inc_nxt   = 1'b0;
    prdata_nxt   = prdata;
    wr_data_nxt  = fifo_write_data;
    wait_cnt_nxt = wait_cnt;
    cap_load     = 1'b0;
    timeout_set  = 1'b0;
    clr_timeout  = 1'b0;
    clr_badtag   = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (is_chan) begin
            if (!pwrite) begin
              prdata_nxt = shadow[chan_idx];
              pready_nxt = 1'b1;
            end else if (!fifo_write_full) begin
              wr_data_nxt = {chan_idx, pwdata};
              wr_inc_nxt  = 1'b1;
              pready_nxt  = 1'b1;
            end else begin
              cap_load     = 1'b1;
              wait_cnt_nxt = '0;
            end
          end else if (is_status) begin
            if (pwrite) begin
              clr_timeout = pwdata[2];
              clr_badtag  = pwdata[3];
            end else begin
              prdata_nxt = status_val;
            end
            pready_nxt = 1'b1;
          end else begin
            prdata_nxt  = '0;
            pready_nxt  = 1'b1;
            pslverr_nxt = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!fifo_write_full) begin
          wr_data_nxt = {cap_tag, cap_data};
          wr_inc_nxt  = 1'b1;
          pready_nxt  = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          pready_nxt  = 1'b1;
          pslverr_nxt = 1'b1;
          timeout_set = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Response and write-FIFO registers.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      pready          <= 1'b0;
      pslverr         <= 1'b0;
      prdata          <= '0;
      fifo_write_inc  <= 1'b0;
      fifo_write_data <= '0;
      wait_cnt        <= '0;
      cap_tag         <= '0;
      cap_data        <= '0;
    end else begin
      pready          <= pready_nxt;
      pslverr         <= pslverr_nxt;
      prdata          <= prdata_nxt;
      fifo_write_inc  <= wr_inc_nxt;
      fifo_write_data <= wr_data_nxt;
      wait_cnt        <= wait_cnt_nxt;
      if (cap_load) begin
        cap_tag  <= chan_idx;
        cap_data <= pwdata;
      end
    end
  end

  // Read-FIFO drain and status flags. A set event in the same cycle as a W1C
  // clear wins; the drop count restarts at 1 in that case.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      fifo_read_inc <= 1'b0;
      timeout_flag  <= 1'b0;
      badtag_flag   <= 1'b0;
      drop_cnt      <= '0;
      for (int i = 0; i < NREG; i++) shadow[i] <= '0;
    end else begin
      fifo_read_inc <= pop;
      if (pop && rd_tag_ok) shadow[rd_tag] <= rd_data;
      timeout_flag <= timeout_set | (timeout_flag & ~clr_timeout);
      badtag_flag  <= badtag_set | (badtag_flag & ~clr_badtag);
      if (clr_badtag)                         drop_cnt <= badtag_set ? 8'd1 : 8'd0;
      else if (badtag_set && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
